led_vu_meter: RTL

LED_VU_METER -- requirements
Module: led_vu_meter

---
 rtl/led_vu_meter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/led_vu_meter.sv
// Stereo VU bar-graph: peak magnitude, log-scale level, peak hold and
// timed one-segment-per-tick decay onto an 8-LED bar.
module led_vu_meter #(
    parameter int DECAY_TICKS = 2500000,
    parameter int HOLD_TICKS  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid,
    input  logic signed [15:0] lft_out,
    input  logic signed [15:0] rht_out,
    output logic [7:0]         LED
);

    localparam int CW = $clog2(DECAY_TICKS);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DECAY = 2'd2;

    logic [14:0]   mag_q, mag_d;
    logic          v2_q, v2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    pk_q, pk_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    led_q, led_d;

    logic [14:0] abs_l, abs_r;
    logic [3:0]  level;
    logic        tick;
    logic        upd;

    // |-32768| is the only value that does not fit in 15 bits
    function automatic logic [14:0] mag15(input logic signed [15:0] x);
        logic [15:0] a;
        a = x[15] ? 16'(-x) : 16'(x);
        return a[15] ? 15'h7FFF : a[14:0];
    endfunction

    assign abs_l = mag15(lft_out);
    assign abs_r = mag15(rht_out);
    assign tick  = (cnt_q == CW'(DECAY_TICKS - 1));

    always_comb begin
        mag_d = mag_q;
        if (valid) begin
            mag_d = (abs_l > abs_r) ? abs_l : abs_r;
        end
        v2_d  = valid;
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_comb begin
        level = 4'd0;
        for (int k = 0; k < 8; k++) begin
            if (mag_q >= (15'd128 << k)) begin
                level = level + 4'd1;
            end
        end
    end

    // A qualifying update wins over a coincident tick
    always_comb begin
        state_d = state_q;
        pk_d    = pk_q;
        hold_d  = hold_q;
        upd     = v2_q && (level >= pk_q) && (level != 4'd0);
        if (upd) begin
            pk_d    = level;
            hold_d  = HW'(HOLD_TICKS);
            state_d = S_HOLD;
        end else if (tick) begin
            case (state_q)
                S_HOLD: begin
                    if (hold_q <= HW'(1)) begin
                        state_d = S_DECAY;
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
                S_DECAY: begin
                    if (pk_q <= 4'd1) begin
                        pk_d    = 4'd0;
                        state_d = S_IDLE;
                    end else begin
                        pk_d = pk_q - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        led_d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            led_d[i] = (pk_q > 4'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q   <= '0;
            v2_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
            pk_q    <= 4'd0;
            hold_q  <= '0;
            led_q   <= 8'h00;
        end else begin
            mag_q   <= mag_d;
            v2_q    <= v2_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            pk_q    <= pk_d;
            hold_q  <= hold_d;
            led_q   <= led_d;
        end
    end

    assign LED = led_q;

endmodule
